// File: rtl/fifo_packet_arbiter_pkg.sv
// Shared helpers for the packet arbiter: modular index arithmetic and entry sizing.
package fifo_packet_arbiter_pkg;

  // (a + b) mod n, for a < n and b < n; avoids a divider in the rotate logic.
  function automatic int wrap_add(input int a, input int b, input int n);
    int sum;
    sum = a + b;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

  function automatic int entry_width(input int source_width, input int data_width);
    return source_width + 1 + data_width;
  endfunction

endpackage

// File: rtl/fifo_packet_arbiter_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally from storage.
module sync_fifo #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_en,
  input  logic             enqueue_en,
  input  logic [WIDTH-1:0] enqueue_data,
  input  logic             dequeue_en,
  output logic [WIDTH-1:0] dequeue_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int AW = $clog2(SIZE);

  logic [WIDTH-1:0] mem [SIZE];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             do_enq;
  logic             do_deq;

  assign count        = wr_ptr - rd_ptr;
  assign empty        = (count == '0);
  assign full         = (count == (AW+1)'(SIZE));
  assign almost_full  = (count >= (AW+1)'(SIZE - 1));
  assign almost_empty = (count <= (AW+1)'(1));
  assign do_enq       = enqueue_en && !full;
  assign do_deq       = dequeue_en && !empty;
  assign dequeue_data = mem[rd_ptr[AW-1:0]];

  // Flush wins over any same-cycle enqueue or dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !flush_en) mem[wr_ptr[AW-1:0]] <= enqueue_data;
  end

endmodule

// File: rtl/fifo_packet_arbiter.sv
// Round-robin packet arbiter feeding one shared FIFO; a packet holds the grant
// from its first accepted beat until its last accepted beat.
module fifo_packet_arbiter
  import fifo_packet_arbiter_pkg::*;
#(
  parameter int  NUM_REQUESTERS = 4,
  parameter int  WIDTH          = 64,
  parameter int  FIFO_SIZE      = 8,
  localparam int SOURCE_WIDTH   = $clog2(NUM_REQUESTERS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush_en,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS-1:0]            req_last,
  input  logic [NUM_REQUESTERS-1:0][WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  output logic                                 out_empty,
  input  logic                                 out_dequeue_en,
  output logic [WIDTH-1:0]                     out_data,
  output logic [SOURCE_WIDTH-1:0]              out_source,
  output logic                                 out_last
);

  localparam int EW = entry_width(SOURCE_WIDTH, WIDTH);

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  typedef struct packed {
    logic [SOURCE_WIDTH-1:0] source;
    logic                    last;
    logic [WIDTH-1:0]        data;
  } entry_t;

  arb_state_t              state;
  logic [SOURCE_WIDTH-1:0] ptr;
  logic [SOURCE_WIDTH-1:0] owner;

  logic [NUM_REQUESTERS-1:0] rotated;
  logic                      any_grant;
  logic [SOURCE_WIDTH-1:0]   grant_idx;
  logic                      accept;
  logic                      accept_last;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      unused_almost;
  logic                      almost_full;
  logic                      almost_empty;
  logic [EW-1:0]             fifo_head;
  entry_t                    entry;
  entry_t                    head;

  // Rotate so the priority pointer sits at bit 0, pick the lowest set bit,
  // then rotate the index back into requester numbering.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      rotated[k] = req_valid[SOURCE_WIDTH'(wrap_add(int'(ptr), k, NUM_REQUESTERS))];
    end
  end

  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    if (state == ST_LOCKED) begin
      any_grant = 1'b1;
      grant_idx = owner;
    end else begin
      for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
        if (rotated[k]) begin
          any_grant = 1'b1;
          grant_idx = SOURCE_WIDTH'(wrap_add(int'(ptr), k, NUM_REQUESTERS));
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (any_grant && !fifo_full && !flush_en && !reset) req_ready[grant_idx] = 1'b1;
  end

  assign accept      = |(req_valid & req_ready);
  assign accept_last = req_last[grant_idx];

  always_comb begin
    entry        = '0;
    entry.source = grant_idx;
    entry.last   = req_last[grant_idx];
    entry.data   = req_data[grant_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else if (flush_en) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else if (accept) begin
      if (accept_last) begin
        state <= ST_IDLE;
        ptr   <= SOURCE_WIDTH'(wrap_add(int'(grant_idx), 1, NUM_REQUESTERS));
      end else begin
        state <= ST_LOCKED;
        owner <= grant_idx;
      end
    end
  end

  sync_fifo #(
    .SIZE  (FIFO_SIZE),
    .WIDTH (EW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_en     (flush_en),
    .enqueue_en   (accept),
    .enqueue_data (entry),
    .dequeue_en   (out_dequeue_en),
    .dequeue_data (fifo_head),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  assign unused_almost = almost_full ^ almost_empty;

  assign head       = fifo_head;
  assign out_empty  = fifo_empty;
  assign out_data   = head.data;
  assign out_source = head.source;
  assign out_last   = head.last;

  dequeue_when_empty: assert property (@(posedge clk) disable iff (reset)
    !(out_dequeue_en && out_empty));

endmodule

// File: tb/tb_fifo_packet_arbiter.sv
// Directed bench for fifo_packet_arbiter: expected grants are fixed per step and
// accepted beats are queued as expected FIFO entries for the consumer side.
module tb_fifo_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;
  localparam int W  = SW + 1 + DW;

  logic                 clk;
  logic                 reset;
  logic                 flush_en;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_last;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic                 out_empty;
  logic                 out_dequeue_en;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_source;
  logic                 out_last;

  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic         deq_mode = 1'b0;

  fifo_packet_arbiter #(
    .NUM_REQUESTERS (N),
    .WIDTH          (DW),
    .FIFO_SIZE      (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_en       (flush_en),
    .req_valid      (req_valid),
    .req_last       (req_last),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .out_empty      (out_empty),
    .out_dequeue_en (out_dequeue_en),
    .out_data       (out_data),
    .out_source     (out_source),
    .out_last       (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l);
    req_valid = v;
    req_last  = l;
    for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom};
  endtask

  // One cycle: inputs already driven just after a posedge; checks at negedge.
  task automatic step(input logic [N-1:0] exp_ready, input string tag);
    logic [W-1:0] exp_head;
    logic [W-1:0] got_head;
    out_dequeue_en = deq_mode && (exp_q.size() != 0);
    @(negedge clk);
    check({tag, "_ready"}, req_ready, exp_ready);
    check({tag, "_empty"}, out_empty, (exp_q.size() == 0));
    if (exp_q.size() != 0) begin
      exp_head = exp_q[0];
      got_head = {out_source, out_last, out_data};
      check({tag, "_head"}, got_head, exp_head);
    end
    if (flush_en) exp_q.delete();
    else if (out_dequeue_en && exp_q.size() != 0) void'(exp_q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && exp_ready[i]) exp_q.push_back({SW'(i), req_last[i], req_data[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    drive('0, '0);
    deq_mode = 1'b1;
    for (int n = 0; n < 12 && exp_q.size() != 0; n++) step('0, tag);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_empty_after"}, out_empty, 1'b1);
  endtask

  initial begin
    reset          = 1'b1;
    flush_en       = 1'b0;
    out_dequeue_en = 1'b0;
    drive(4'b1111, 4'b1111);
    #3;
    check("reset_ready", req_ready, 4'b0000);
    check("reset_empty", out_empty, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_ready_hold", req_ready, 4'b0000);
    reset = 1'b0;

    // Fairness with single-beat packets.
    deq_mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      drive(4'b1111, 4'b1111); step(4'b0001, "rr0");
      drive(4'b1111, 4'b1111); step(4'b0010, "rr1");
      drive(4'b1111, 4'b1111); step(4'b0100, "rr2");
      drive(4'b1111, 4'b1111); step(4'b1000, "rr3");
    end
    drain("rr_drain");

    // Packet lock: req1 three beats, req2 waits.
    drive(4'b0110, 4'b0000); step(4'b0010, "lock_b0");
    drive(4'b0110, 4'b0000); step(4'b0010, "lock_b1");
    drive(4'b0110, 4'b0110); step(4'b0010, "lock_b2");
    drive(4'b0100, 4'b0100); step(4'b0100, "lock_r2");
    drain("lock_drain");

    // Owner bubble: pointer is 3, req0 owns, req3 waits through the bubble.
    drive(4'b0001, 4'b0000); step(4'b0001, "bub_b0");
    drive(4'b1001, 4'b1000); step(4'b0001, "bub_b1");
    drive(4'b1000, 4'b1000); step(4'b0001, "bub_gap0");
    drive(4'b1000, 4'b1000); step(4'b0001, "bub_gap1");
    drive(4'b1001, 4'b1001); step(4'b0001, "bub_b2");
    drive(4'b1000, 4'b1000); step(4'b1000, "bub_r3");
    drain("bub_drain");

    // Full backpressure with req2 streaming and no consumer.
    deq_mode = 1'b0;
    for (int b = 0; b < 8; b++) begin
      drive(4'b0100, 4'b0100); step(4'b0100, "full_fill");
    end
    drive(4'b0100, 4'b0100); step(4'b0000, "full_hold0");
    drive(4'b0100, 4'b0100); step(4'b0000, "full_hold1");
    deq_mode = 1'b1;
    drive(4'b0100, 4'b0100); step(4'b0000, "full_deq_same");
    deq_mode = 1'b0;
    drive(4'b0100, 4'b0100); step(4'b0100, "full_ninth");
    drive(4'b0100, 4'b0100); step(4'b0000, "full_again");
    drain("full_drain");

    // Flush mid-packet: pointer moved to 1 first so a reset pointer is visible.
    deq_mode = 1'b0;
    drive(4'b0001, 4'b0001); step(4'b0001, "fl_single");
    drive(4'b0001, 4'b0000); step(4'b0001, "fl_b0");
    drive(4'b0001, 4'b0000); step(4'b0001, "fl_b1");
    deq_mode = 1'b1;
    flush_en = 1'b1;
    drive(4'b0011, 4'b0011); step(4'b0000, "fl_pulse");
    flush_en = 1'b0;
    drive(4'b0011, 4'b0011); step(4'b0001, "fl_after0");
    drive(4'b0010, 4'b0010); step(4'b0010, "fl_after1");
    drain("fl_drain");

    // Flush while req2 owns the grant: arbiter must return to IDLE.
    drive(4'b0100, 4'b0000); step(4'b0100, "fl2_b0");
    flush_en = 1'b1;
    drive(4'b0000, 4'b0000); step(4'b0000, "fl2_pulse");
    flush_en = 1'b0;
    drive(4'b0010, 4'b0010); step(4'b0010, "fl2_idle");
    drain("fl2_drain");

    // Async reset in the middle of streaming; pointer is 1 before reset.
    drive(4'b1111, 4'b1111); step(4'b0100, "ar_s0");
    drive(4'b1111, 4'b1111); step(4'b1000, "ar_s1");
    drive(4'b1111, 4'b1111); step(4'b0001, "ar_s2");
    #2;
    reset          = 1'b1;
    out_dequeue_en = 1'b0;
    #1;
    check("ar_ready", req_ready, 4'b0000);
    check("ar_empty", out_empty, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("ar_ready_hold", req_ready, 4'b0000);
    reset = 1'b0;
    drive(4'b1111, 4'b1111); step(4'b0001, "ar_r0");
    drive(4'b1111, 4'b1111); step(4'b0010, "ar_r1");
    drain("ar_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
